// File: rtl/switch_pkg.sv
// Shared switch types: MAC type, table entry, lookup FSM states, group-bit helper.
// The entry hit bit exists only when MAC_TABLE_AGING_EN is defined.
package switch_pkg;

    typedef logic [47:0] mac_t;

    // The egress port lives in a per-entry array beside this struct: its width follows NUM_PORTS.
    typedef struct packed {
        logic valid;
`ifdef MAC_TABLE_AGING_EN
        logic hit;
`endif
        mac_t mac;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        RESPOND
    } state_t;

    localparam mac_t BROADCAST_MAC = 48'hFFFF_FFFF_FFFF;

    function automatic logic is_group(input mac_t mac);
        return mac[40];
    endfunction

endpackage

// File: rtl/mac_table_age_timer.sv
// Free-running aging timer: counts 0..AGE_PERIOD-1 and pulses tick on the wrap cycle.
// Instantiated by mac_address_table only when MAC_TABLE_AGING_EN is defined.
module mac_table_age_timer #(
    parameter int AGE_PERIOD = 1000000
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);

    localparam int CW = (AGE_PERIOD > 1) ? $clog2(AGE_PERIOD) : 1;

    logic [CW-1:0] count_q;

    assign tick = (count_q == CW'(AGE_PERIOD - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else if (tick) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + CW'(1);
        end
    end

endmodule

// File: rtl/mac_address_table.sv
// MAC learning / forwarding-decision table: one request in, one egress port mask out.
// Optional entry aging is compiled in with MAC_TABLE_AGING_EN.
module mac_address_table
    import switch_pkg::*;
#(
    parameter int NUM_PORTS  = 4,
    parameter int DEPTH      = 16,
    parameter int AGE_PERIOD = 1000000,
    localparam int PORT_W    = $clog2(NUM_PORTS),
    localparam int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 lookup_valid,
    output logic                 lookup_ready,
    input  mac_t                 lookup_src_mac,
    input  mac_t                 lookup_dst_mac,
    input  logic [PORT_W-1:0]    lookup_src_port,
    output logic                 result_valid,
    input  logic                 result_ready,
    output logic [NUM_PORTS-1:0] result_port_mask,
    output logic [CNT_W-1:0]     entry_count,
    output state_t               debug_state
);

    localparam int IDX_W = $clog2(DEPTH);

    if (NUM_PORTS < 2) begin : g_bad_ports
        $error("NUM_PORTS must be at least 2");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of two, at least 2");
    end
    if (AGE_PERIOD < 1) begin : g_bad_age
        $error("AGE_PERIOD must be at least 1");
    end

    state_t              state_q, state_d;
    mac_t                req_src, req_dst;
    logic [PORT_W-1:0]   req_port;
    entry_t              table_q [DEPTH];
    logic [PORT_W-1:0]   port_q  [DEPTH];
    logic [IDX_W-1:0]    victim_q;
    logic [NUM_PORTS-1:0] mask_q, mask_d, src_onehot;

    logic                dst_hit, src_hit, free_found;
    logic [IDX_W-1:0]    dst_idx, src_idx, free_idx, learn_idx;
    logic                learn_en, evict;

`ifdef MAC_TABLE_AGING_EN
    logic age_tick;

    mac_table_age_timer #(.AGE_PERIOD(AGE_PERIOD)) u_age_timer (
        .clock (clock),
        .reset (reset),
        .tick  (age_tick)
    );
`endif

    // Handshakes: a transfer happens on a rising edge where valid && ready; the producer
    // holds valid and its payload until then, and ready never waits on valid.
    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        lookup_ready = 1'b0;
        result_valid = 1'b0;
        case (state_q)
            IDLE: begin
                lookup_ready = 1'b1;
                if (lookup_valid) state_d = COMPARE;
            end
            COMPARE: state_d = RESPOND;
            RESPOND: begin
                result_valid = 1'b1;
                if (result_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign debug_state      = state_q;
    assign result_port_mask = mask_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            req_src  <= '0;
            req_dst  <= '0;
            req_port <= '0;
        end else if (state_q == IDLE && lookup_valid) begin
            req_src  <= lookup_src_mac;
            req_dst  <= lookup_dst_mac;
            req_port <= lookup_src_port;
        end
    end

    // Descending scan so the last assignment wins: lowest matching / lowest free index.
    always_comb begin
        dst_hit    = 1'b0;
        dst_idx    = '0;
        src_hit    = 1'b0;
        src_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (table_q[i].valid && table_q[i].mac == req_dst) begin
                dst_hit = 1'b1;
                dst_idx = IDX_W'(i);
            end
            if (table_q[i].valid && table_q[i].mac == req_src) begin
                src_hit = 1'b1;
                src_idx = IDX_W'(i);
            end
            if (!table_q[i].valid) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    assign src_onehot = NUM_PORTS'(1) << req_port;

    always_comb begin
        mask_d = ~src_onehot;
        if (is_group(req_dst))                         mask_d = ~src_onehot;
        else if (dst_hit && port_q[dst_idx] == req_port) mask_d = '0;
        else if (dst_hit)                              mask_d = NUM_PORTS'(1) << port_q[dst_idx];
    end

    assign learn_en  = (state_q == COMPARE) && !is_group(req_src);
    assign evict     = learn_en && !src_hit && !free_found;
    assign learn_idx = src_hit ? src_idx : (free_found ? free_idx : victim_q);

    always_ff @(posedge clock) begin
        if (reset) mask_q <= '0;
        else if (state_q == COMPARE) mask_q <= mask_d;
    end

    // The learn write comes after the aging sweep so it wins on a shared entry.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                table_q[i] <= '0;
                port_q[i]  <= '0;
            end
            victim_q <= '0;
        end else begin
`ifdef MAC_TABLE_AGING_EN
            if (age_tick) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (!table_q[i].hit) table_q[i].valid <= 1'b0;
                    table_q[i].hit <= 1'b0;
                end
            end
`endif
            if (learn_en) begin
                table_q[learn_idx].valid <= 1'b1;
`ifdef MAC_TABLE_AGING_EN
                table_q[learn_idx].hit   <= 1'b1;
`endif
                table_q[learn_idx].mac   <= req_src;
                port_q[learn_idx]        <= req_port;
            end
            if (evict) victim_q <= victim_q + IDX_W'(1);
        end
    end

    always_comb begin
        entry_count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entry_count = entry_count + CNT_W'(table_q[i].valid);
        end
    end

endmodule

// File: tb/tb_mac_address_table.sv
// Bench for mac_address_table: slot-level table model, per-cycle compare, directed requests.
// Aging checks are included when MAC_TABLE_AGING_EN is defined.
module tb_mac_address_table;
    import switch_pkg::*;

    localparam int NUM_PORTS  = 4;
    localparam int DEPTH      = 4;
    localparam int AGE_PERIOD = 100;
    localparam int PORT_W     = 2;
    localparam int CNT_W      = 3;

    logic                 clock, reset;
    logic                 lookup_valid, lookup_ready;
    mac_t                 lookup_src_mac, lookup_dst_mac;
    logic [PORT_W-1:0]    lookup_src_port;
    logic                 result_valid, result_ready;
    logic [NUM_PORTS-1:0] result_port_mask;
    logic [CNT_W-1:0]     entry_count;
    state_t               debug_state;

    mac_address_table #(
        .NUM_PORTS(NUM_PORTS), .DEPTH(DEPTH), .AGE_PERIOD(AGE_PERIOD)
    ) dut (
        .clock(clock), .reset(reset),
        .lookup_valid(lookup_valid), .lookup_ready(lookup_ready),
        .lookup_src_mac(lookup_src_mac), .lookup_dst_mac(lookup_dst_mac),
        .lookup_src_port(lookup_src_port),
        .result_valid(result_valid), .result_ready(result_ready),
        .result_port_mask(result_port_mask), .entry_count(entry_count),
        .debug_state(debug_state)
    );

    // ---------------- clock ----------------
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- model ----------------
    logic  m_valid [DEPTH];
    mac_t  m_mac   [DEPTH];
    int    m_port  [DEPTH];
    logic  m_hit   [DEPTH];
    int    m_victim, m_age;
    logic  m_idle, m_pend, m_resp;
    mac_t  c_src, c_dst;
    int    c_port;
    logic [NUM_PORTS-1:0] exp_q[$];

    function automatic logic [NUM_PORTS-1:0] model_decide();
        logic [NUM_PORTS-1:0] flood, oh;
        flood = '1;
        flood[c_port] = 1'b0;
        oh = '0;
        if (c_dst[40]) return flood;
        for (int i = 0; i < DEPTH; i++) begin
            if (m_valid[i] && m_mac[i] == c_dst) begin
                if (m_port[i] == c_port) return '0;
                oh[m_port[i]] = 1'b1;
                return oh;
            end
        end
        return flood;
    endfunction

    function automatic int model_count();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) if (m_valid[i]) n++;
        return n;
    endfunction

    always @(posedge clock) begin : model
        logic acc, learn_now, ev;
        int   tgt;
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_valid[i] = 1'b0; m_mac[i] = '0; m_port[i] = 0; m_hit[i] = 1'b0;
            end
            m_victim = 0; m_age = 0;
            m_idle = 1'b1; m_pend = 1'b0; m_resp = 1'b0;
            exp_q.delete();
        end else begin
            acc = lookup_valid && m_idle;
            learn_now = 1'b0; ev = 1'b0; tgt = -1;
            if (m_resp && result_ready) begin
                void'(exp_q.pop_front());
                m_resp = 1'b0;
                m_idle = 1'b1;
            end
            if (m_pend) begin
                exp_q.push_back(model_decide());
                m_pend = 1'b0;
                m_resp = 1'b1;
                if (!c_src[40]) begin
                    learn_now = 1'b1;
                    for (int i = 0; i < DEPTH; i++)
                        if (tgt < 0 && m_valid[i] && m_mac[i] == c_src) tgt = i;
                    for (int i = 0; i < DEPTH; i++)
                        if (tgt < 0 && !m_valid[i]) tgt = i;
                    if (tgt < 0) begin
                        tgt = m_victim;
                        ev  = 1'b1;
                    end
                end
            end
`ifdef MAC_TABLE_AGING_EN
            if (m_age == AGE_PERIOD - 1) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (!m_hit[i]) m_valid[i] = 1'b0;
                    m_hit[i] = 1'b0;
                end
                m_age = 0;
            end else begin
                m_age++;
            end
`endif
            if (learn_now) begin
                m_valid[tgt] = 1'b1; m_hit[tgt] = 1'b1;
                m_mac[tgt] = c_src;  m_port[tgt] = c_port;
                if (ev) m_victim = (m_victim + 1) % DEPTH;
            end
            if (acc) begin
                c_src = lookup_src_mac; c_dst = lookup_dst_mac; c_port = int'(lookup_src_port);
                m_pend = 1'b1;
                m_idle = 1'b0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        @(posedge clock);
        forever begin
            #1;
            chk("cyc_lookup_ready", lookup_ready, m_idle);
            chk("cyc_result_valid", result_valid, m_resp);
            if (m_resp && exp_q.size() > 0) chk("cyc_mask", result_port_mask, exp_q[0]);
            chk("cyc_entry_count", entry_count, model_count());
            @(posedge clock);
        end
    end

    // ---------------- driver ----------------
    task automatic do_req(input mac_t src, input mac_t dst, input int port,
                          input logic [NUM_PORTS-1:0] exp_mask, input int exp_cnt,
                          input int hold, input string name);
        int n;
        n = 0;
        while (!lookup_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!lookup_ready) begin
            chk({name, "_idle_timeout"}, 0, 1);
            return;
        end
        lookup_valid = 1'b1;
        lookup_src_mac = src;
        lookup_dst_mac = dst;
        lookup_src_port = PORT_W'(port);
        @(negedge clock);
        lookup_valid = 1'b0;
        n = 1;
        while (!result_valid && n < 10) begin
            @(negedge clock);
            n++;
        end
        chk({name, "_latency"}, n, 2);
        if (!result_valid) return;
        chk({name, "_mask"}, result_port_mask, exp_mask);
        if (exp_cnt >= 0) chk({name, "_count"}, entry_count, exp_cnt);
        repeat (hold) @(negedge clock);
        result_ready = 1'b1;
        @(negedge clock);
        result_ready = 1'b0;
    endtask

    localparam mac_t A1 = 48'h02_00_00_00_00_01;
    localparam mac_t A2 = 48'h02_00_00_00_00_02;
    localparam mac_t A3 = 48'h02_00_00_00_00_03;
    localparam mac_t A4 = 48'h02_00_00_00_00_04;
    localparam mac_t A5 = 48'h02_00_00_00_00_05;
    localparam mac_t A6 = 48'h02_00_00_00_00_06;
    localparam mac_t A7 = 48'h02_00_00_00_00_07;
    localparam mac_t A8 = 48'h02_00_00_00_00_08;
    localparam mac_t A9 = 48'h02_00_00_00_00_09;
    localparam mac_t GRP = 48'h01_00_5E_00_00_01;

    // ---------------- main sequence ----------------
    initial begin
        reset = 1'b1;
        lookup_valid = 1'b0;
        lookup_src_mac = '0;
        lookup_dst_mac = '0;
        lookup_src_port = '0;
        result_ready = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        chk("reset_count", entry_count, 0);
        chk("reset_ready", lookup_ready, 1);
        chk("reset_valid", result_valid, 0);
        chk("reset_mask", result_port_mask, 0);
        chk("reset_state", debug_state, IDLE);

        do_req(A1, A2, 1, 4'b1101, 1, 0, "first_learn");
        do_req(A2, A1, 3, 4'b0010, 2, 0, "unicast_hit");
        do_req(A1, A1, 1, 4'b0000, 2, 0, "filter_same_port");
        do_req(A3, BROADCAST_MAC, 0, 4'b1110, 3, 0, "broadcast");
        do_req(GRP, A2, 2, 4'b1000, 3, 0, "group_src_no_learn");
        do_req(A4, A9, 2, 4'b1011, 4, 0, "fill_table");
        do_req(A5, A1, 0, 4'b0010, 4, 0, "evict_entry0");
        do_req(A6, A3, 1, 4'b0001, 4, 0, "evict_entry1");
        do_req(A7, A1, 2, 4'b1011, 4, 0, "evicted_floods");
        do_req(A4, A5, 3, 4'b0001, 4, 0, "station_move");
        do_req(A6, A4, 1, 4'b1000, 4, 10, "hold_ready_low");

        // reset while a response is waiting
        lookup_valid = 1'b1;
        lookup_src_mac = A8;
        lookup_dst_mac = A9;
        lookup_src_port = 2'd0;
        @(negedge clock);
        lookup_valid = 1'b0;
        @(negedge clock);
        chk("midrst_pending_valid", result_valid, 1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("midrst_valid", result_valid, 0);
        chk("midrst_count", entry_count, 0);
        chk("midrst_ready", lookup_ready, 1);

        do_req(A1, A6, 2, 4'b1011, 1, 0, "after_reset_flood");

`ifdef MAC_TABLE_AGING_EN
        do_req(48'h02_00_00_00_00_0A, BROADCAST_MAC, 0, 4'b1110, 2, 0, "age_learn_b1");
        do_req(48'h02_00_00_00_00_0B, 48'h02_00_00_00_00_0A, 1, 4'b0001, 3, 0, "age_learn_b2");
        repeat (100) @(negedge clock);
        do_req(48'h02_00_00_00_00_0B, BROADCAST_MAC, 1, 4'b1101, 3, 0, "age_refresh_b2");
        repeat (100) @(negedge clock);
        do_req(48'h02_00_00_00_00_0C, 48'h02_00_00_00_00_0A, 2, 4'b1011, 2, 0, "aged_out_floods");
        do_req(48'h02_00_00_00_00_0D, 48'h02_00_00_00_00_0B, 3, 4'b0010, 3, 0, "refreshed_survives");
`endif

        repeat (3) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mac_address_table.md
# mac_address_table

Parametrised MAC learning and forwarding-decision table for the multi-port generation of the switch, which replaces the single-port top-level path. Each received frame header (source MAC, destination MAC, ingress port) is presented once. The block learns the source address against its ingress port and returns an egress port mask: unicast hit, filtered, or flood. It sits between the per-port receive transceivers and the frame-forwarding fabric, in the `clock` domain.

## Interface
- NUM_PORTS, 4, number of switch ports (≥2); PORT_W = $clog2(NUM_PORTS) localparam
- DEPTH, 16, table entries (power of two, ≥2), fully associative
- AGE_PERIOD, 1000000, cycles between aging sweeps (used only with aging compiled in)

- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- lookup_valid  in  1  request present
- lookup_ready  out  1  block can accept; high only in IDLE
- lookup_src_mac  in  48  source MAC; bit 40 = group bit of first octet [47:40]
- lookup_dst_mac  in  48  destination MAC
- lookup_src_port  in  PORT_W  ingress port; values ≥ NUM_PORTS are illegal
- result_valid  out  1  decision available; held until accepted
- result_ready  in  1  consumer accepts the decision
- result_port_mask  out  NUM_PORTS  egress ports, bit i = port i
- entry_count  out  $clog2(DEPTH+1)  number of valid entries

## Operation
- Entry: valid, mac[47:0], port[PORT_W-1:0], hit.
- FSM:
  - IDLE (ready=1): on valid&&ready, capture the request → COMPARE.
  - COMPARE: parallel-compare the captured dst and src against all valid entries, register the mask, apply the learn write → RESPOND.
  - RESPOND: result_valid=1; on result_ready → IDLE.
- The destination decision uses the table state before this request's learn. A frame with src==dst is therefore not resolved by its own learn.
- Destination rules, in priority order:
  - dst bit 40 = 1 (multicast/broadcast): flood = all ports except src_port.
  - dst hit and entry.port == src_port: mask = 0 (filter).
  - dst hit: one-hot(entry.port).
  - dst miss: flood.
- Learn rules:
  - src bit 40 = 1: no learn.
  - src hit: overwrite port (station move); set hit=1.
  - src miss, free entry exists: write the lowest-index invalid entry; valid=1, hit=1.
  - src miss, table full: overwrite the entry at victim_ptr; victim_ptr increments mod DEPTH (wraps DEPTH-1→0). entry_count is unchanged.
- victim_ptr advances only on an eviction.
- entry_count is updated in the same cycle as the write that changes it.

## Timing
- Request accepted at edge T; result_valid rises at T+2; learn write is visible from T+2.
- Minimum request spacing is 3 cycles. lookup_ready=0 from T+1 until the cycle after the result handshake.
- result_port_mask is stable while result_valid && !result_ready.
- Reset values: state IDLE (lookup_ready=1), result_valid=0, result_port_mask=0, entry_count=0, all entries invalid, victim_ptr=0, age counter=0.
- Reset mid-operation: any pending request or response is discarded and the table is cleared. The response is never delivered.

## Configuration
- MAC_TABLE_AGING_EN defined:
  - An age counter counts 0..AGE_PERIOD-1 and pulses a tick on wrap.
  - On a tick, every valid entry with hit=0 is invalidated; then hit is cleared on all entries.
  - The tick runs in every FSM state.
  - If a tick coincides with the COMPARE learn write, the compare uses pre-tick state. The written entry ends the cycle valid with hit=1, and entry_count reflects both operations.
- MAC_TABLE_AGING_EN undefined: no counter and no hit bit. Entries persist until reset and are displaced only by eviction.

## Structure
- Shared package switch_pkg:
  - typedef mac_t (logic [47:0]);
  - entry struct;
  - FSM state enum (IDLE, COMPARE, RESPOND);
  - constant BROADCAST_MAC = 48'hFFFF_FFFF_FFFF;
  - function is_group(mac_t), returning bit 40.
- Sub-module mac_table_age_timer (AGE_PERIOD counter, tick output) is instantiated only under MAC_TABLE_AGING_EN.
- Compare, learn and FSM logic live in mac_address_table.

## Test plan
- After reset: src 02:00:00:00:00:01 port 1, dst 02:00:00:00:00:02 → mask 4'b1101; entry_count=1; result_valid at T+2.
- Next request: src 02:…:02 port 3, dst 02:…:01 → mask 4'b0010. Then src …:01 port 1, dst …:01 → mask 0 (filter).
- dst FF:FF:FF:FF:FF:FF from port 0 → 4'b1110. A src with bit 40 set (01:00:5E:00:00:01) is not learned; entry_count unchanged.
- DEPTH=4, learn 5 distinct sources: the 5th replaces entry 0, the 6th replaces entry 1; entry_count stays 4. The evicted MAC then floods.
- Hold result_ready=0 for 10 cycles: result_valid and the mask stay stable, lookup_ready=0. Assert reset during RESPOND: result_valid=0 next cycle, table empty.
- With MAC_TABLE_AGING_EN and AGE_PERIOD=100: entry untouched for two ticks → invalidated, dst floods. Entry refreshed as src between ticks → survives.
